// File: rtl/fpga_cmd_rx_if.sv
// SPI link between the ARM (master) and the FPGA command receiver (slave).
// spck/mosi/ncs are asynchronous to the receiver clock; miso is driven back to the ARM.
interface fpga_cmd_rx_if;
  logic spck;
  logic mosi;
  logic ncs;
  logic miso;

  modport master (output spck, output mosi, output ncs, input miso);
  modport slave  (input spck, input mosi, input ncs, output miso);
endinterface

// File: rtl/fpga_cmd_rx.sv
// SPI command receiver: oversamples the ARM's SPI lines at 13.56 MHz, decodes 16-bit
// command words into conf_word/divisor and shifts a status word back out on miso.
module fpga_cmd_rx (
  input  logic               ck_1356meg,
  input  logic               nreset,
  fpga_cmd_rx_if.slave       spi,
  output logic [7:0]         conf_word,
  output logic [7:0]         divisor,
  output logic               conf_stb,
  output logic               div_stb,
  output logic               frame_err
);

  // [0] = s1, [1] = s2, [2] = s3 (edge-detect delay)
  logic [2:0]  spck_sync_r;
  logic [2:0]  mosi_sync_r;
  logic [2:0]  ncs_sync_r;
  logic [4:0]  bit_cnt_r;
  logic [15:0] shift_reg_r;
  logic [15:0] miso_sr_r;
  logic        miso_r;
  logic [7:0]  conf_word_r;
  logic [7:0]  divisor_r;
  logic [3:0]  err_cnt_r;
  logic        conf_stb_r;
  logic        div_stb_r;
  logic        frame_err_r;

  logic        spck_rise_s;
  logic        spck_fall_s;
  logic        ncs_fall_s;
  logic        ncs_rise_s;
  logic        ncs_low_s;
  logic        shift_en_s;
  logic        readback_en_s;
  logic [15:0] status_s;
  logic [4:0]  bit_cnt_base_s;
  logic [4:0]  bit_cnt_next_s;
  logic        conf_wr_s;
  logic        div_wr_s;
  logic        err_s;
  logic        unused_bits_s;

  assign spck_rise_s   = spck_sync_r[1] & ~spck_sync_r[2];
  assign spck_fall_s   = ~spck_sync_r[1] & spck_sync_r[2];
  assign ncs_fall_s    = ~ncs_sync_r[1] & ncs_sync_r[2];
  assign ncs_rise_s    = ncs_sync_r[1] & ~ncs_sync_r[2];
  assign ncs_low_s     = ~ncs_sync_r[1];
  assign shift_en_s    = spck_rise_s & ncs_low_s;
  assign readback_en_s = spck_fall_s & ncs_low_s & ~ncs_fall_s;
  assign status_s      = {4'b1010, err_cnt_r, conf_word_r};
  assign unused_bits_s = &{1'b0, shift_reg_r[11:8], mosi_sync_r[2]};

  assign spi.miso  = miso_r;
  assign conf_word = conf_word_r;
  assign divisor   = divisor_r;
  assign conf_stb  = conf_stb_r;
  assign div_stb   = div_stb_r;
  assign frame_err = frame_err_r;

  // Synchronise the asynchronous SPI pins into the local clock domain.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      spck_sync_r <= 3'b000;
      mosi_sync_r <= 3'b000;
      ncs_sync_r  <= 3'b111;
    end else begin
      spck_sync_r <= {spck_sync_r[1:0], spi.spck};
      mosi_sync_r <= {mosi_sync_r[1:0], spi.mosi};
      ncs_sync_r  <= {ncs_sync_r[1:0], spi.ncs};
    end
  end

  // Bit counter: a frame start clears first, so a coincident spck rise counts as bit 1.
  always_comb begin
    bit_cnt_base_s = bit_cnt_r;
    bit_cnt_next_s = bit_cnt_r;
    if (ncs_fall_s) begin
      bit_cnt_base_s = 5'd0;
    end else begin
      bit_cnt_base_s = bit_cnt_r;
    end
    if (shift_en_s && (bit_cnt_base_s != 5'd17)) begin
      bit_cnt_next_s = bit_cnt_base_s + 5'd1;
    end else begin
      bit_cnt_next_s = bit_cnt_base_s;
    end
  end

  // Frame decode at ncs rise; only exact 16-bit frames may touch the registers.
  always_comb begin
    conf_wr_s = 1'b0;
    div_wr_s  = 1'b0;
    err_s     = 1'b0;
    if (ncs_rise_s) begin
      case (bit_cnt_r)
        5'd0: begin
          err_s = 1'b0;
        end
        5'd16: begin
          case (shift_reg_r[15:12])
            4'b0001: conf_wr_s = 1'b1;
            4'b0010: div_wr_s  = 1'b1;
            default: err_s     = 1'b0;
          endcase
        end
        default: err_s = 1'b1;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Frame state, readback shifter and configuration registers.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      bit_cnt_r   <= 5'd0;
      shift_reg_r <= 16'h0000;
      miso_sr_r   <= 16'h0000;
      miso_r      <= 1'b0;
      conf_word_r <= 8'hE0;
      divisor_r   <= 8'h00;
      err_cnt_r   <= 4'd0;
      conf_stb_r  <= 1'b0;
      div_stb_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      bit_cnt_r <= bit_cnt_next_s;
      if (shift_en_s) begin
        shift_reg_r <= {shift_reg_r[14:0], mosi_sync_r[1]};
      end
      if (ncs_fall_s) begin
        miso_sr_r <= status_s;
      end else if (readback_en_s) begin
        miso_sr_r <= {miso_sr_r[14:0], 1'b0};
      end
      // miso mirrors the MSB of the readback shifter and idles low outside a frame
      if (!ncs_low_s) begin
        miso_r <= 1'b0;
      end else if (ncs_fall_s) begin
        miso_r <= status_s[15];
      end else if (readback_en_s) begin
        miso_r <= miso_sr_r[14];
      end
      if (conf_wr_s) begin
        conf_word_r <= shift_reg_r[7:0];
      end
      if (div_wr_s) begin
        divisor_r <= shift_reg_r[7:0];
      end
      if (err_s && (err_cnt_r != 4'd15)) begin
        err_cnt_r <= err_cnt_r + 4'd1;
      end
      conf_stb_r  <= conf_wr_s;
      div_stb_r   <= div_wr_s;
      frame_err_r <= err_s;
    end
  end

endmodule

// File: tb/tb_fpga_cmd_rx.sv
// Self-checking bench for fpga_cmd_rx: drives SPI frames with random spck phases and
// compares registers, strobe timing and miso readback against a frame-level model.
module tb_fpga_cmd_rx;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] conf_word;
  logic [7:0] divisor;
  logic       conf_stb;
  logic       div_stb;
  logic       frame_err;

  fpga_cmd_rx_if bus ();

  fpga_cmd_rx dut (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .spi        (bus),
    .conf_word  (conf_word),
    .divisor    (divisor),
    .conf_stb   (conf_stb),
    .div_stb    (div_stb),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stb_total = 0;

  // Model state: what the registers should hold after each completed frame
  logic [7:0] conf_m = 8'hE0;
  logic [7:0] div_m  = 8'h00;
  logic [3:0] err_m  = 4'd0;

  always @(negedge clk) stb_total <= stb_total + 32'(conf_stb) + 32'(div_stb) + 32'(frame_err);

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level rules: {conf_stb, div_stb, frame_err} expected for a frame of n bits
  task automatic model_frame(input logic [31:0] data, input int n, output logic [2:0] vec);
    vec = 3'b000;
    if (n == 16) begin
      if (data[15:12] == 4'b0001) begin
        conf_m = data[7:0];
        vec = 3'b100;
      end else if (data[15:12] == 4'b0010) begin
        div_m = data[7:0];
        vec = 3'b010;
      end
    end else if (n != 0) begin
      if (err_m != 4'd15) err_m = err_m + 4'd1;
      vec = 3'b001;
    end
  endtask

  task automatic spi_start();
    @(negedge clk);
    bus.ncs = 1'b0;
    wait_clk(5);
  endtask

  // Shift n bits MSB first; cap[i] is miso as seen just before the i-th spck rise
  task automatic spi_bits(input logic [31:0] data, input int n, output logic [31:0] cap);
    int h;
    cap = 32'h0;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(5, 8);
      bus.mosi = data[n-1-i];
      wait_clk(h);
      cap[i] = bus.miso;
      bus.spck = 1'b1;
      wait_clk(h);
      bus.spck = 1'b0;
    end
  endtask

  task automatic spi_end(input string name, input logic [2:0] exp_vec, input logic chk_rb,
                         input logic [15:0] status, input int n, input logic [31:0] cap,
                         input int stb_start);
    logic [17:0] hist;
    logic [17:0] exp_hist;
    logic [31:0] stream;
    logic [31:0] exp_cap;
    wait_clk(5);
    bus.ncs = 1'b1;
    hist = 18'h0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      hist = {hist[14:0], conf_stb, div_stb, frame_err};
    end
    exp_hist = {6'b0, exp_vec, 9'b0};
    checks++;
    if (hist !== exp_hist) begin
      failures++;
      $display("FAIL %s strobe_timing: got %b want %b", name, hist, exp_hist);
    end
    wait_clk(2);
    checks++;
    if ((stb_total - stb_start) != $countones(exp_vec)) begin
      failures++;
      $display("FAIL %s strobe_count: got %0d want %0d", name, stb_total - stb_start, $countones(exp_vec));
    end
    checks++;
    if (conf_word !== conf_m || divisor !== div_m) begin
      failures++;
      $display("FAIL %s regs: got conf=%h div=%h want conf=%h div=%h", name, conf_word, divisor, conf_m, div_m);
    end
    checks++;
    if (bus.miso !== 1'b0) begin
      failures++;
      $display("FAIL %s miso_idle: got %b want 0", name, bus.miso);
    end
    if (chk_rb) begin
      stream = {status, 16'h0};
      exp_cap = 32'h0;
      for (int i = 0; i < n; i++) exp_cap[i] = stream[31-i];
      checks++;
      if (cap !== exp_cap) begin
        failures++;
        $display("FAIL %s readback: got %h want %h", name, cap, exp_cap);
      end
    end
  endtask

  task automatic do_frame(input string name, input logic [31:0] data, input int n,
                          output logic [31:0] cap);
    logic [15:0] status;
    logic [2:0]  vec;
    int          s0;
    status = {4'hA, err_m, conf_m};
    s0 = stb_total;
    spi_start();
    spi_bits(data, n, cap);
    model_frame(data, n, vec);
    spi_end(name, vec, 1'b1, status, n, cap, s0);
  endtask

  task automatic test_reset();
    bus.spck = 1'b0;
    bus.mosi = 1'b0;
    bus.ncs  = 1'b1;
    nreset = 1'b0;
    wait_clk(5);
    checks++;
    if (conf_word !== 8'hE0 || divisor !== 8'h00 || bus.miso !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got conf=%h div=%h miso=%b want E0 00 0", conf_word, divisor, bus.miso);
    end
    nreset = 1'b1;
    wait_clk(4);
    checks++;
    if ({conf_stb, div_stb, frame_err} !== 3'b000 || conf_word !== 8'hE0 || divisor !== 8'h00) begin
      failures++;
      $display("FAIL reset_release: got stb=%b conf=%h div=%h want 000 E0 00",
               {conf_stb, div_stb, frame_err}, conf_word, divisor);
    end
  endtask

  task automatic test_set_config();
    logic [31:0] cap;
    do_frame("set_config", 32'h1041, 16, cap);
    checks++;
    if (conf_word !== 8'h41 || divisor !== 8'h00) begin
      failures++;
      $display("FAIL set_config_value: got conf=%h div=%h want 41 00", conf_word, divisor);
    end
  endtask

  task automatic test_divisor_unknown();
    logic [31:0] cap;
    do_frame("set_divisor", 32'h205F, 16, cap);
    do_frame("unknown_op", 32'h70FF, 16, cap);
    checks++;
    if (divisor !== 8'h5F || conf_word !== 8'h41) begin
      failures++;
      $display("FAIL divisor_value: got div=%h conf=%h want 5F 41", divisor, conf_word);
    end
  endtask

  task automatic test_bad_length();
    logic [31:0] cap;
    do_frame("len15", $urandom, 15, cap);
    do_frame("len17", $urandom, 17, cap);
    do_frame("len0", 32'h0, 0, cap);
  endtask

  task automatic test_readback();
    logic [31:0] cap;
    logic [15:0] word;
    do_frame("readback", 32'h0000, 16, cap);
    for (int i = 0; i < 16; i++) word[15-i] = cap[i];
    checks++;
    if (word !== 16'hA241) begin
      failures++;
      $display("FAIL readback_word: got %h want A241", word);
    end
  endtask

  task automatic test_random();
    logic [31:0] cap;
    logic [31:0] data;
    logic [3:0]  op;
    int          sel;
    int          n;
    for (int f = 0; f < 24; f++) begin
      sel = $urandom_range(0, 3);
      op  = (sel == 0) ? 4'b0001 : (sel == 1) ? 4'b0010 : 4'($urandom);
      data = {16'h0, op, 12'($urandom)};
      n = ($urandom_range(0, 9) < 7) ? 16 : $urandom_range(0, 17);
      if (n != 16) data = $urandom;
      do_frame("random", data, n, cap);
    end
  endtask

  task automatic test_err_saturation();
    logic [31:0] cap;
    for (int f = 0; f < 15; f++) do_frame("err_sat", $urandom, 1, cap);
    do_frame("err_sat_readback", 32'h7000, 16, cap);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] cap;
    logic [31:0] data;
    logic [2:0]  vec;
    int          s0;
    spi_start();
    spi_bits($urandom, 8, cap);
    nreset = 1'b0;
    wait_clk(3);
    nreset = 1'b1;
    conf_m = 8'hE0;
    div_m  = 8'h00;
    err_m  = 4'd0;
    wait_clk(5);
    s0 = stb_total;
    data = $urandom;
    spi_bits(data, 8, cap);
    model_frame(data, 8, vec);
    spi_end("reset_mid_frame", vec, 1'b0, 16'h0, 8, cap, s0);
    do_frame("after_reset_readback", 32'h0000, 16, cap);
  endtask

  initial begin
    test_reset();
    test_set_config();
    test_divisor_unknown();
    test_bad_length();
    test_readback();
    test_random();
    test_err_saturation();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
